addr_stream_reader: RTL and testbench

- Downstream consumer of the nested address generator. Each accepted address becomes one SRAM read.
- Drives the generator's step input, so the generator advances only when an address is actually issued.
- Tracks fixed-latency read returns and buffers them in a small FIFO. Read data is presented on a ready/valid stream.
- Runs one transfer of num_addrs reads per start pulse, with credit-based backpressure so no return is ever dropped.

---
 rtl/addr_stream_reader.sv | 185 ++++++++++++++++++
 tb/tb_addr_stream_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_stream_reader.sv
// Issues one SRAM read per generator address, tracks fixed-latency returns and
// buffers them in a credit-guarded FIFO that feeds a ready/valid output stream.
module addr_stream_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_addrs,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              step_out,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int RES_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [RES_W-1:0] RES_FULL = RES_W'(FIFO_DEPTH);
  localparam logic [RES_W-1:0] RES_ONE  = RES_W'(1);
  localparam logic [RES_W-1:0] RES_ZERO = {RES_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                busy_q, done_q;
  logic [RES_W-1:0]    reserved_q, reserved_d;
  logic [RES_W-1:0]    count_q, count_d;
  logic [RD_LATENCY-1:0] rvalid_q;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic                issue_s, push_s, pop_s;

  // Credit is checked against the registered count, so a pop never frees a slot for the same cycle.
  assign issue_s = (state_q == S_RUN) && (remaining_q != CNT_ZERO) && (reserved_q < RES_FULL);
  assign push_s  = rvalid_q[RD_LATENCY-1];
  assign pop_s   = (count_q != RES_ZERO) && data_ready;

  assign step_out   = issue_s;
  assign mem_ren    = issue_s;
  assign mem_addr   = addr_in;
  assign data_out   = fifo_mem_q[rptr_q];
  assign data_valid = (count_q != RES_ZERO);
  assign busy       = busy_q;
  assign done       = done_q;

  // Next state of the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_addrs != CNT_ZERO) begin
            state_d     = S_RUN;
            remaining_d = num_addrs;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (issue_s) begin
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (reserved_q == RES_ZERO) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Credit and FIFO occupancy bookkeeping.
  always_comb begin
    reserved_d = reserved_q;
    count_d    = count_q;
    case ({issue_s, pop_s})
      2'b10:   reserved_d = reserved_q + RES_ONE;
      2'b01:   reserved_d = reserved_q - RES_ONE;
      default: reserved_d = reserved_q;
    endcase
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + RES_ONE;
      2'b01:   count_d = count_q - RES_ONE;
      default: count_d = count_q;
    endcase
  end

  // Sequencer state with busy/done registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= CNT_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  // Return-valid pipeline; clearing it on reset discards reads still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= {RD_LATENCY{1'b0}};
    end else begin
      for (int i = 1; i < RD_LATENCY; i++) begin
        rvalid_q[i] <= rvalid_q[i-1];
      end
      rvalid_q[0] <= issue_s;
    end
  end

  // Credit counter, occupancy and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reserved_q <= RES_ZERO;
      count_q    <= RES_ZERO;
      wptr_q     <= {PTR_W{1'b0}};
      rptr_q     <= {PTR_W{1'b0}};
    end else begin
      reserved_q <= reserved_d;
      count_q    <= count_d;
      if (push_s) begin
        wptr_q <= wptr_q + PTR_ONE;
      end else begin
        wptr_q <= wptr_q;
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PTR_ONE;
      end else begin
        rptr_q <= rptr_q;
      end
    end
  end

  // Return buffer storage; no bypass, so a push into an empty FIFO shows up next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_mem_q[wptr_q] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_addr_stream_reader.sv
// Self-checking bench: a linear address generator and a 2-cycle SRAM model feed
// the reader; results are compared with addresses/data derived from base+i*stride.
module tb_addr_stream_reader;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [CNT_W-1:0] num_addrs;
  logic [ADDR_W-1:0] addr_in;
  logic step_out, mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] data_out;
  logic data_valid, data_ready, busy, done;

  int total, bad;

  always #5 clk = ~clk;

  addr_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_addrs(num_addrs),
    .addr_in(addr_in), .step_out(step_out), .mem_ren(mem_ren),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .done(done)
  );

  function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
    return (a * 16'd40503) ^ 16'h5A3C;
  endfunction

  // SRAM model: address captured mid-cycle T, data presented during cycle T+2
  logic [ADDR_W-1:0] sram_a0, sram_a1, sram_a2;
  always @(negedge clk) sram_a0 <= mem_addr;
  always @(posedge clk) begin
    sram_a1 <= sram_a0;
    sram_a2 <= sram_a1;
  end
  assign mem_rdata = sram_word(sram_a2);

  // Linear generator: advances on the edge ending a step_out cycle
  logic gen_load, step_n;
  logic [ADDR_W-1:0] gen_base, gen_stride, gen_addr;
  always @(negedge clk) step_n <= step_out;
  always @(posedge clk) begin
    if (gen_load) gen_addr <= gen_base;
    else if (step_n) gen_addr <= gen_addr + gen_stride;
  end
  assign addr_in = gen_addr;

  // Per-run observations
  logic [ADDR_W-1:0] r_iss_addr[$];
  int r_iss_cyc[$];
  logic [DATA_W-1:0] r_pop_data[$];
  int r_pop_cyc[$];
  int r_done_cyc[$];
  int r_busy_n, r_first_valid, r_max_res, r_stab_err, r_ren_err;
  logic r_timeout;

  task automatic run_transfer(input int n, input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                              input int rmode, input int hold_until, input int xs1, input int xs2, input int max_cyc);
    int c;
    int res;
    bit stop;
    bit hold_prev;
    logic [DATA_W-1:0] hold_data;
    r_iss_addr.delete(); r_iss_cyc.delete(); r_pop_data.delete(); r_pop_cyc.delete(); r_done_cyc.delete();
    r_busy_n = 0; r_first_valid = -1; r_max_res = 0; r_stab_err = 0; r_ren_err = 0; r_timeout = 1'b0;
    hold_prev = 1'b0; hold_data = '0; stop = 1'b0;
    gen_base = base; gen_stride = stride; gen_load = 1'b1;
    @(posedge clk); #1;
    gen_load = 1'b0;
    @(posedge clk); #1;
    c = 0;
    start = 1'b1;
    num_addrs = n[CNT_W-1:0];
    data_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 9) < 6) : (c >= hold_until);
    while (!stop) begin
      @(negedge clk);
      res = r_iss_addr.size() - r_pop_data.size();
      if (res > r_max_res) r_max_res = res;
      if (hold_prev && !(data_valid === 1'b1 && data_out === hold_data)) r_stab_err++;
      hold_prev = data_valid && !data_ready;
      hold_data = data_out;
      if (mem_ren !== step_out) r_ren_err++;
      if (step_out === 1'b1) begin
        r_iss_addr.push_back(mem_addr);
        r_iss_cyc.push_back(c);
      end
      if (data_valid === 1'b1 && r_first_valid < 0) r_first_valid = c;
      if (data_valid === 1'b1 && data_ready === 1'b1) begin
        r_pop_data.push_back(data_out);
        r_pop_cyc.push_back(c);
      end
      if (done === 1'b1) r_done_cyc.push_back(c);
      if (busy === 1'b1) r_busy_n++;
      if (r_done_cyc.size() > 0 && c >= r_done_cyc[0] + 2) begin
        stop = 1'b1;
      end else if (c >= max_cyc) begin
        r_timeout = 1'b1;
        stop = 1'b1;
      end else begin
        @(posedge clk); #1;
        c++;
        start = (c == xs1) || (c == xs2);
        num_addrs = start ? 16'd9 : 16'd0;
        data_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 9) < 6) : (c >= hold_until);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    num_addrs = 16'd5;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({step_out, mem_ren, data_valid, busy, done} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {step_out, mem_ren, data_valid, busy, done});
    end
    total++;
    if (data_out !== 16'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0000", data_out);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_start_ignored: busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [ADDR_W-1:0] ea;
    run_transfer(6, 16'h0100, 16'd1, 0, 0, -1, -1, 100);
    total++; if (r_timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout: got 1 want 0"); end
    total++; if (r_iss_addr.size() !== 6) begin bad++; $display("FAIL basic_issues: got %0d want 6", r_iss_addr.size()); end
    for (int i = 0; i < r_iss_addr.size(); i++) begin
      ea = 16'(16'h0100 + i);
      total++; if (r_iss_cyc[i] !== i + 1) begin bad++; $display("FAIL basic_issue_cyc[%0d]: got %0d want %0d", i, r_iss_cyc[i], i + 1); end
      total++; if (r_iss_addr[i] !== ea) begin bad++; $display("FAIL basic_addr[%0d]: got %h want %h", i, r_iss_addr[i], ea); end
    end
    total++; if (r_first_valid !== 4) begin bad++; $display("FAIL basic_first_valid: got %0d want 4", r_first_valid); end
    total++; if (r_pop_data.size() !== 6) begin bad++; $display("FAIL basic_pops: got %0d want 6", r_pop_data.size()); end
    for (int i = 0; i < r_pop_data.size(); i++) begin
      total++; if (r_pop_data[i] !== sram_word(16'(16'h0100 + i))) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, r_pop_data[i], sram_word(16'(16'h0100 + i))); end
    end
    total++; if (r_done_cyc.size() !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", r_done_cyc.size()); end
    if (r_done_cyc.size() > 0) begin
      total++; if (r_done_cyc[0] !== 11) begin bad++; $display("FAIL basic_done_cyc: got %0d want 11", r_done_cyc[0]); end
    end
    total++; if (r_busy_n !== 11) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 11", r_busy_n); end
    total++; if (r_ren_err !== 0) begin bad++; $display("FAIL basic_ren_eq_step: got %0d errors want 0", r_ren_err); end
  endtask

  task automatic test_backpressure();
    int early;
    early = 0;
    run_transfer(6, 16'h0100, 16'd1, 2, 15, -1, -1, 200);
    foreach (r_iss_cyc[i]) if (r_iss_cyc[i] < 15) early++;
    total++; if (r_timeout !== 1'b0) begin bad++; $display("FAIL bp_timeout: got 1 want 0"); end
    total++; if (early !== 4) begin bad++; $display("FAIL bp_stalled_issues: got %0d want 4", early); end
    total++; if (r_iss_addr.size() !== 6) begin bad++; $display("FAIL bp_issues: got %0d want 6", r_iss_addr.size()); end
    if (r_iss_cyc.size() > 4) begin
      total++; if (r_iss_cyc[4] !== 16) begin bad++; $display("FAIL bp_resume_cyc: got %0d want 16", r_iss_cyc[4]); end
    end
    for (int i = 0; i < r_iss_addr.size(); i++) begin
      total++; if (r_iss_addr[i] !== 16'(16'h0100 + i)) begin bad++; $display("FAIL bp_addr[%0d]: got %h want %h", i, r_iss_addr[i], 16'(16'h0100 + i)); end
    end
    total++; if (r_pop_data.size() !== 6) begin bad++; $display("FAIL bp_pops: got %0d want 6", r_pop_data.size()); end
    for (int i = 0; i < r_pop_data.size(); i++) begin
      total++; if (r_pop_data[i] !== sram_word(16'(16'h0100 + i))) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, r_pop_data[i], sram_word(16'(16'h0100 + i))); end
    end
    total++; if (r_stab_err !== 0) begin bad++; $display("FAIL bp_stable: got %0d errors want 0", r_stab_err); end
    total++; if (r_max_res > FIFO_DEPTH) begin bad++; $display("FAIL bp_reserved: got %0d want <=4", r_max_res); end
    total++; if (r_done_cyc.size() !== 1) begin bad++; $display("FAIL bp_done_count: got %0d want 1", r_done_cyc.size()); end
  endtask

  task automatic test_zero();
    run_transfer(0, 16'h0040, 16'd1, 0, 0, -1, -1, 20);
    total++; if (r_iss_addr.size() !== 0) begin bad++; $display("FAIL zero_issues: got %0d want 0", r_iss_addr.size()); end
    total++; if (r_done_cyc.size() !== 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", r_done_cyc.size()); end
    if (r_done_cyc.size() > 0) begin
      total++; if (r_done_cyc[0] !== 1) begin bad++; $display("FAIL zero_done_cyc: got %0d want 1", r_done_cyc[0]); end
    end
    total++; if (r_busy_n !== 1) begin bad++; $display("FAIL zero_busy_cycles: got %0d want 1", r_busy_n); end
    total++; if (r_ren_err !== 0) begin bad++; $display("FAIL zero_ren: got %0d errors want 0", r_ren_err); end
  endtask

  task automatic test_reset_midrun();
    int leaks;
    leaks = 0;
    gen_base = 16'h0200; gen_stride = 16'd1; gen_load = 1'b1;
    @(posedge clk); #1;
    gen_load = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; num_addrs = 16'd5; data_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({step_out, mem_ren, data_valid, busy, done} !== 5'b0 || data_out !== 16'h0) begin
      bad++; $display("FAIL midrst_outputs: got %b/%h want 00000/0000", {step_out, mem_ren, data_valid, busy, done}, data_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (data_valid !== 1'b0 || busy !== 1'b0 || step_out !== 1'b0) leaks++;
    end
    total++; if (leaks !== 0) begin bad++; $display("FAIL midrst_stale_returns: got %0d cycles active want 0", leaks); end
    run_transfer(3, 16'h0300, 16'd2, 0, 0, -1, -1, 60);
    total++; if (r_pop_data.size() !== 3) begin bad++; $display("FAIL midrst_pops: got %0d want 3", r_pop_data.size()); end
    for (int i = 0; i < r_pop_data.size(); i++) begin
      total++; if (r_pop_data[i] !== sram_word(16'(16'h0300 + 2 * i))) begin bad++; $display("FAIL midrst_data[%0d]: got %h want %h", i, r_pop_data[i], sram_word(16'(16'h0300 + 2 * i))); end
    end
  endtask

  task automatic test_ignored_start();
    run_transfer(5, 16'h0400, 16'd3, 0, 0, 3, 7, 100);
    total++; if (r_iss_addr.size() !== 5) begin bad++; $display("FAIL ign_issues: got %0d want 5", r_iss_addr.size()); end
    total++; if (r_done_cyc.size() !== 1) begin bad++; $display("FAIL ign_done_count: got %0d want 1", r_done_cyc.size()); end
    if (r_done_cyc.size() > 0) begin
      total++; if (r_done_cyc[0] !== 10) begin bad++; $display("FAIL ign_done_cyc: got %0d want 10", r_done_cyc[0]); end
    end
    total++; if (r_pop_data.size() !== 5) begin bad++; $display("FAIL ign_pops: got %0d want 5", r_pop_data.size()); end
    for (int i = 0; i < r_pop_data.size(); i++) begin
      total++; if (r_pop_data[i] !== sram_word(16'(16'h0400 + 3 * i))) begin bad++; $display("FAIL ign_data[%0d]: got %h want %h", i, r_pop_data[i], sram_word(16'(16'h0400 + 3 * i))); end
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] base, stride, ea;
    base = 16'($urandom_range(0, 65535));
    stride = 16'($urandom_range(1, 9));
    run_transfer(200, base, stride, 1, 0, -1, -1, 3000);
    total++; if (r_timeout !== 1'b0) begin bad++; $display("FAIL rnd_timeout: got 1 want 0"); end
    total++; if (r_iss_addr.size() !== 200) begin bad++; $display("FAIL rnd_issues: got %0d want 200", r_iss_addr.size()); end
    total++; if (r_pop_data.size() !== 200) begin bad++; $display("FAIL rnd_pops: got %0d want 200", r_pop_data.size()); end
    for (int i = 0; i < r_iss_addr.size(); i++) begin
      ea = 16'(base + i * stride);
      total++; if (r_iss_addr[i] !== ea) begin bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, r_iss_addr[i], ea); end
    end
    for (int i = 0; i < r_pop_data.size(); i++) begin
      ea = 16'(base + i * stride);
      total++; if (r_pop_data[i] !== sram_word(ea)) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, r_pop_data[i], sram_word(ea)); end
    end
    total++; if (r_max_res > FIFO_DEPTH) begin bad++; $display("FAIL rnd_reserved: got %0d want <=4", r_max_res); end
    total++; if (r_stab_err !== 0) begin bad++; $display("FAIL rnd_stable: got %0d errors want 0", r_stab_err); end
    total++; if (r_ren_err !== 0) begin bad++; $display("FAIL rnd_ren_eq_step: got %0d errors want 0", r_ren_err); end
    total++; if (r_done_cyc.size() !== 1) begin bad++; $display("FAIL rnd_done_count: got %0d want 1", r_done_cyc.size()); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    num_addrs = '0;
    data_ready = 1'b0;
    gen_load = 1'b1;
    gen_base = '0;
    gen_stride = 16'd1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_reset_midrun();
    test_ignored_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
